vending_ctrl_multi: RTL and testbench

- Parametrised successor to the single-product vending FSM.
- Accepts coins of three configurable denominations and sells one of N_ITEMS products, each at its own price.
- Returns change one coin at a time over a valid/ready handshake, largest coin first.
- Supports cancel/refund and a mode where unused credit is kept for a further purchase instead of being returned.
- Sits between the coin acceptor front-end and the dispenser/hopper drivers.

---
 rtl/vending_ctrl_multi.sv | 173 +++++++++++++++++
 tb/tb_vending_ctrl_multi.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller.
// Accepts three coin denominations, sells one of N_ITEMS products at
// per-item prices, and pays change one coin at a time over valid/ready,
// largest coin first. Cancel refunds the credit. AUTO_CHANGE selects
// between returning the remainder and keeping it for another purchase.
module vending_ctrl_multi #(
  parameter int                          N_ITEMS     = 4,
  parameter int                          CREDIT_W    = 8,
  parameter int                          COIN_V1     = 5,
  parameter int                          COIN_V2     = 10,
  parameter int                          COIN_V3     = 20,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES      = {8'd40, 8'd25, 8'd20, 8'd15},
  parameter int                          MAX_CREDIT  = 60,
  parameter int                          AUTO_CHANGE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_valid,
  input  logic [1:0]                 coin_code,
  input  logic                       sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0] sel_item,
  input  logic                       cancel,
  output logic                       dispense,
  output logic [$clog2(N_ITEMS)-1:0] dispense_item,
  output logic                       change_valid,
  output logic [1:0]                 change_coin,
  input  logic                       change_ready,
  output logic                       coin_reject,
  output logic                       sel_short,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       busy
);

  localparam int SEL_W = $clog2(N_ITEMS);

  localparam logic [CREDIT_W-1:0] V1    = CREDIT_W'(COIN_V1);
  localparam logic [CREDIT_W-1:0] V2    = CREDIT_W'(COIN_V2);
  localparam logic [CREDIT_W-1:0] V3    = CREDIT_W'(COIN_V3);
  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  // Value of a coin code; code 0 is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd1:    return V1;
      2'd2:    return V2;
      2'd3:    return V3;
      default: return '0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic                reject_q, reject_d;
  logic                short_q, short_d;

  // Largest change coin that still fits in the remaining credit. Credit is
  // always a multiple of the smallest coin, so code 1 is the floor.
  logic [1:0] big_code;
  assign big_code = (credit_q >= V3) ? 2'd3 :
                    (credit_q >= V2) ? 2'd2 : 2'd1;

  // State and data registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      short_q  <= short_d;
    end
  end

  // Next-state and next-credit logic.
  always_comb begin
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] eff;
    logic [CREDIT_W-1:0] price;
    logic                sel_known;
    logic [CREDIT_W-1:0] change_val;

    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    credit_d  = credit_q;
    item_d    = item_q;
    reject_d  = 1'b0;
    short_d   = 1'b0;

    // Coin acceptance: the extra sum bit keeps the overflow check exact.
    coin_val  = coin_value(coin_code);
    sum       = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok   = coin_valid && (coin_code != 2'd0) && (sum <= {1'b0, MAX_C});
    eff       = coin_ok ? sum[CREDIT_W-1:0] : credit_q;

    // Price lookup; indices beyond N_ITEMS stay unknown and count as short.
    price     = '0;
    sel_known = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) begin
        price     = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_known = 1'b1;
      end
    end

    change_val = coin_value(big_code);

    case (state_q)
      S_IDLE, S_COLLECT: begin
        reject_d = coin_valid && !coin_ok;
        if (cancel && (state_q == S_COLLECT)) begin
          // Refund everything, including a coin accepted this very cycle.
          state_d  = S_CHANGE;
          credit_d = eff;
        end else if (sel_valid && sel_known && (eff >= price)) begin
          state_d  = S_DISPENSE;
          credit_d = eff - price;
          item_d   = sel_item;
        end else begin
          short_d  = sel_valid;
          credit_d = eff;
          state_d  = (eff != '0) ? S_COLLECT : S_IDLE;
        end
      end
      S_DISPENSE: begin
        reject_d = coin_valid;
        if (credit_q == '0)
          state_d = S_IDLE;
        else if (AUTO_CHANGE != 0)
          state_d = S_CHANGE;
        else
          state_d = S_COLLECT;
      end
      S_CHANGE: begin
        reject_d = coin_valid;
        if (change_ready) begin
          credit_d = credit_q - change_val;
          if (credit_q == change_val)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and pulse flags.
  always_comb begin
    dispense      = (state_q == S_DISPENSE);
    dispense_item = dispense ? item_q : '0;
    change_valid  = (state_q == S_CHANGE);
    change_coin   = change_valid ? big_code : 2'd0;
    busy          = dispense || change_valid;
    coin_reject   = reject_q;
    sel_short     = short_q;
    credit        = credit_q;
  end

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Bench for vending_ctrl_multi: two instances (remainder returned / kept)
// share one input stream; a transaction-level model predicts each of them
// and is compared every cycle, with literal expectations on the directed
// scenarios followed by a randomized run.
module tb_vending_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b0;

  logic       a_disp, a_cv, a_rej, a_short, a_busy;
  logic [1:0] a_item, a_cc;
  logic [7:0] a_credit;
  logic       k_disp, k_cv, k_rej, k_short, k_busy;
  logic [1:0] k_item, k_cc;
  logic [7:0] k_credit;

  int  errors = 0;
  int  checks = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  vending_ctrl_multi dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .dispense(a_disp), .dispense_item(a_item), .change_valid(a_cv),
    .change_coin(a_cc), .change_ready(change_ready), .coin_reject(a_rej),
    .sel_short(a_short), .credit(a_credit), .busy(a_busy)
  );

  vending_ctrl_multi #(.AUTO_CHANGE(0)) dut_keep (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .dispense(k_disp), .dispense_item(k_item), .change_valid(k_cv),
    .change_coin(k_cc), .change_ready(change_ready), .coin_reject(k_rej),
    .sel_short(k_short), .credit(k_credit), .busy(k_busy)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int credit;
    bit disp;     // a product is being released this cycle
    int item;
    bit reject;
    bit shrt;
    bit refund;   // money is being paid back
  } mstate_t;

  mstate_t ma, mk;

  function automatic int coin_val(input int code);
    case (code)
      1:       return 5;
      2:       return 10;
      3:       return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input int item);
    case (item)
      0:       return 15;
      1:       return 20;
      2:       return 25;
      default: return 40;
    endcase
  endfunction

  function automatic int big_coin(input int amount);
    for (int c = 3; c >= 1; c--)
      if (coin_val(c) <= amount) return c;
    return 0;
  endfunction

  function automatic mstate_t model_next(input mstate_t m, input bit keep_rest,
                                         input bit cv, input int cc, input bit sv,
                                         input int si, input bit cn, input bit rdy);
    mstate_t n;
    int      v;
    int      eff;
    bit      ok;
    n        = m;
    n.reject = 1'b0;
    n.shrt   = 1'b0;
    if (m.disp) begin
      n.disp   = 1'b0;
      n.reject = cv;
      if (m.credit > 0 && !keep_rest) n.refund = 1'b1;
    end else if (m.refund) begin
      n.reject = cv;
      if (rdy) begin
        n.credit = m.credit - coin_val(big_coin(m.credit));
        if (n.credit == 0) n.refund = 1'b0;
      end
    end else begin
      v        = cv ? coin_val(cc) : 0;
      ok       = (v != 0) && (m.credit + v <= 60);
      n.reject = cv && !ok;
      eff      = m.credit + (ok ? v : 0);
      n.credit = eff;
      if (cn && m.credit > 0) begin
        n.refund = 1'b1;
      end else if (sv) begin
        if (si < 4 && eff >= price_of(si)) begin
          n.disp   = 1'b1;
          n.item   = si;
          n.credit = eff - price_of(si);
        end else begin
          n.shrt = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{default: 0};
      mk <= '{default: 0};
    end else begin
      ma <= model_next(ma, 1'b0, coin_valid, int'(coin_code), sel_valid,
                       int'(sel_item), cancel, change_ready);
      mk <= model_next(mk, 1'b1, coin_valid, int'(coin_code), sel_valid,
                       int'(sel_item), cancel, change_ready);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mstate_t m,
                         input logic d, input logic [1:0] it, input logic cv,
                         input logic [1:0] cc, input logic rj, input logic sh,
                         input logic [7:0] cr, input logic bz);
    check({tag, ".dispense"},      d,  m.disp);
    check({tag, ".dispense_item"}, it, m.disp ? m.item : 0);
    check({tag, ".change_valid"},  cv, m.refund);
    check({tag, ".change_coin"},   cc, m.refund ? big_coin(m.credit) : 0);
    check({tag, ".coin_reject"},   rj, m.reject);
    check({tag, ".sel_short"},     sh, m.shrt);
    check({tag, ".credit"},        cr, m.credit);
    check({tag, ".busy"},          bz, m.disp || m.refund);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("auto", ma, a_disp, a_item, a_cv, a_cc, a_rej, a_short, a_credit, a_busy);
      cmp_dut("keep", mk, k_disp, k_item, k_cv, k_cc, k_rej, k_short, k_credit, k_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit cv, input int cc, input bit sv, input int si,
                     input bit cn, input bit rdy);
    coin_valid   = cv;
    coin_code    = 2'(cc);
    sel_valid    = sv;
    sel_item     = 2'(si);
    cancel       = cn;
    change_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((a_busy || k_busy) && n < 20) begin
      idle(1'b1);
      n++;
    end
    check({name, ".drain_done"}, a_busy || k_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.credit",   a_credit, 0);
    check("rst.change",   a_cv, 0);
    check("rst.dispense", a_disp, 0);
    check("rst.busy",     k_busy, 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Scenario 1: three 5-coins, buy item 0 (15).
    cyc(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    check("s1.credit5", a_credit, 5);
    check("s1.model5",  ma.credit, 5);
    cyc(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    check("s1.credit10", a_credit, 10);
    cyc(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    check("s1.credit15", a_credit, 15);
    cyc(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    check("s1.dispense", a_disp, 1);
    check("s1.item",     a_item, 0);
    check("s1.credit0",  a_credit, 0);
    idle(1'b0);
    check("s1.no_change", a_cv, 0);
    check("s1.idle",      a_busy, 0);

    // Scenario 2: 20-coin and select item 0 together; 5 comes back.
    cyc(1'b1, 3, 1'b1, 0, 1'b0, 1'b0);
    check("s2.dispense", a_disp, 1);
    check("s2.credit",   a_credit, 5);
    check("s2.model",    ma.credit, 5);
    idle(1'b0);
    check("s2.change_valid", a_cv, 1);
    check("s2.change_coin",  a_cc, 1);
    check("s2.keep_credit",  k_credit, 5);
    idle(1'b1);
    check("s2.done_valid",  a_cv, 0);
    check("s2.done_credit", a_credit, 0);

    // Scenario 3: credit 40, buy item 0, ready held low, then 20 + 5 back.
    do_reset();
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    check("s3.credit40", a_credit, 40);
    cyc(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    check("s3.credit25", a_credit, 25);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("s3.hold_coin",   a_cc, 3);
      check("s3.hold_credit", a_credit, 25);
    end
    idle(1'b1);
    check("s3.second_coin", a_cc, 1);
    check("s3.after_20",    a_credit, 5);
    idle(1'b1);
    check("s3.done", a_cv, 0);

    // Scenario 4: short selection, then cancel beats select.
    do_reset();
    cyc(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
    check("s4.short",    a_short, 1);
    check("s4.credit",   a_credit, 10);
    check("s4.no_disp",  a_disp, 0);
    idle(1'b0);
    check("s4.short_end", a_short, 0);
    cyc(1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
    check("s4.cancel_nodisp", a_disp, 0);
    check("s4.refund_valid",  a_cv, 1);
    check("s4.refund_coin",   a_cc, 2);
    idle(1'b1);
    check("s4.refund_done", a_credit, 0);

    // Scenario 5: overflow reject, then a coin during change.
    do_reset();
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
    check("s5.credit50", a_credit, 50);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    check("s5.reject",       a_rej, 1);
    check("s5.credit_kept",  a_credit, 50);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    check("s5.refund_coin", a_cc, 3);
    cyc(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    check("s5.reject_in_change", a_rej, 1);
    check("s5.remainder",        a_credit, 50);
    drain("s5");

    // Scenario 6: remainder kept as credit; then reset during change.
    do_reset();
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    check("s6.keep_disp", k_disp, 1);
    idle(1'b0);
    check("s6.keep_credit25", k_credit, 25);
    check("s6.keep_busy",     k_busy, 0);
    check("s6.keep_nochange", k_cv, 0);
    check("s6.model25",       mk.credit, 25);
    cyc(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
    check("s6.keep_disp2", k_disp, 1);
    check("s6.keep_item2", k_item, 2);
    check("s6.keep_empty", k_credit, 0);
    idle(1'b0);
    check("s6.auto_in_change", a_cv, 1);
    #2 rst = 1'b1;
    #1;
    check("s6.async_valid",  a_cv, 0);
    check("s6.async_credit", a_credit, 0);
    check("s6.async_busy",   a_busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      end
    end
    drain("rand");

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
